// File: rtl/ir_nec_receiver.sv
// NEC infrared remote decoder. It measures marks and spaces in slow ticks and queues the
// decoded {address, command} codes. Define IR_NEC_REPEAT_EN to also queue repeat codes.

module ir_nec_receiver #(
    parameter int TICK_DIV   = 1750,
    parameter int FIFO_DEPTH = 4,
    parameter int TOL_LEAD   = 40,
    parameter int TOL_BIT    = 10,
    parameter int CHECK_CMD  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir,
    output logic [15:0] code_data,
    output logic        code_repeat,
    output logic        code_valid,
    input  logic        code_ready,
    output logic        err,
    output logic        overflow
);

    localparam int         TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int         CW      = PW + 1;
    localparam logic [8:0] DUR_MAX = 9'd511;
`ifdef IR_NEC_REPEAT_EN
    localparam int         EW      = 17;
`else
    localparam int         EW      = 16;
`endif

    typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, DATA, STOP} state_e;

    function automatic logic in_win(input logic [8:0] dur, input int nom, input int tol);
        return (int'(dur) > nom - tol) && (int'(dur) < nom + tol);
    endfunction

    logic ir0_q, ir1_q, ir2_q;
    logic rise, fall;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
        if (rst) begin
            ir0_q <= 1'b0;
            ir1_q <= 1'b0;
            ir2_q <= 1'b0;
        end else begin
            ir0_q <= ir;
            ir1_q <= ir0_q;
            ir2_q <= ir1_q;
        end
    end

    assign rise = !ir2_q && ir1_q;
    assign fall = ir2_q && !ir1_q;

    logic [TW-1:0] tick_q, tick_d;
    logic [8:0]    dur_q, dur_d;
    logic          clr_dur;

    always_comb begin
        tick_d = tick_q;
        dur_d  = dur_q;
        if (rise || fall || clr_dur) begin
            tick_d = '0;
            dur_d  = '0;
        end else if (tick_q == TW'(TICK_DIV - 1)) begin
            tick_d = '0;
            if (dur_q != DUR_MAX) dur_d = dur_q + 9'd1;
        end else begin
            tick_d = tick_q + TW'(1);
        end
    end

    state_e        state_q, state_d;
    logic [4:0]    bits_q, bits_d;
    logic [31:0]   word_q, word_d;
    logic          rep_q, rep_d;
    logic          err_q, err_d;
    logic          push;
    logic [15:0]   push_code;
    logic [EW-1:0] push_entry;
`ifdef IR_NEC_REPEAT_EN
    logic          push_rep;
    logic [15:0]   last_q, last_d;
    logic          last_vld_q, last_vld_d;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        bits_d    = bits_q;
        word_d    = word_q;
        rep_d     = rep_q;
        err_d     = 1'b0;
        clr_dur   = 1'b0;
        push      = 1'b0;
        push_code = {word_q[31:24], word_q[15:8]};
`ifdef IR_NEC_REPEAT_EN
        push_rep   = 1'b0;
        last_d     = last_q;
        last_vld_d = last_vld_q;
`endif
        if (state_q != IDLE && dur_q == DUR_MAX) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    // Clearing here stops a stuck-high input from retriggering a timeout on every cycle.
                    if (ir1_q) begin
                        state_d = LEAD_MARK;
                        clr_dur = 1'b1;
                    end
                end
                LEAD_MARK: begin
                    if (fall) begin
                        if (in_win(dur_q, 257, TOL_LEAD)) begin
                            state_d = LEAD_SPACE;
                        end else begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end
                    end
                end
                LEAD_SPACE: begin
                    if (rise) begin
                        if (in_win(dur_q, 128, TOL_LEAD)) begin
                            state_d = DATA;
                            bits_d  = '0;
                            rep_d   = 1'b0;
                        end else if (in_win(dur_q, 64, TOL_LEAD)) begin
                            state_d = STOP;
                            rep_d   = 1'b1;
                        end else begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (fall && !in_win(dur_q, 16, TOL_BIT)) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else if (rise) begin
                        if (in_win(dur_q, 16, TOL_BIT) || in_win(dur_q, 48, TOL_BIT)) begin
                            word_d = {word_q[30:0], !in_win(dur_q, 16, TOL_BIT)};
                            bits_d = bits_q + 5'd1;
                            if (bits_q == 5'd31) state_d = STOP;
                        end else begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (fall) begin
                        state_d = IDLE;
                        if (!in_win(dur_q, 16, TOL_BIT)) begin
                            err_d = 1'b1;
                        end else if (rep_q) begin
`ifdef IR_NEC_REPEAT_EN
                            if (last_vld_q) begin
                                push      = 1'b1;
                                push_code = last_q;
                                push_rep  = 1'b1;
                            end
`endif
                        end else if (CHECK_CMD != 0 && word_q[7:0] != ~word_q[15:8]) begin
                            err_d = 1'b1;
                        end else begin
                            push = 1'b1;
`ifdef IR_NEC_REPEAT_EN
                            last_d     = {word_q[31:24], word_q[15:8]};
                            last_vld_d = 1'b1;
`endif
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef IR_NEC_REPEAT_EN
    assign push_entry = {push_rep, push_code};
`else
    assign push_entry = push_code;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bits_q  <= '0;
            word_q  <= '0;
            rep_q   <= 1'b0;
            err_q   <= 1'b0;
            tick_q  <= '0;
            dur_q   <= '0;
`ifdef IR_NEC_REPEAT_EN
            last_q     <= '0;
            last_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            word_q  <= word_d;
            rep_q   <= rep_d;
            err_q   <= err_d;
            tick_q  <= tick_d;
            dur_q   <= dur_d;
`ifdef IR_NEC_REPEAT_EN
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
`endif
        end
    end

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] head;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          pop, full, do_push;

    assign pop     = code_valid && code_ready;
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (push && !do_push) ovf_q <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; count_q defines occupancy and the outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head       = mem_q[rd_ptr_q];
    assign code_valid = (count_q != '0);
    assign code_data  = code_valid ? head[15:0] : 16'h0000;
`ifdef IR_NEC_REPEAT_EN
    assign code_repeat = code_valid && head[16];
`else
    assign code_repeat = 1'b0;
`endif
    assign err      = err_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ir_nec_receiver.sv
// Directed bench for ir_nec_receiver: frames built from NEC timing rules, a queue model of the
// expected decoded codes, and per-cycle comparison of the head entry whenever it is popped.

module tb_ir_nec_receiver;

    localparam int TD    = 4;
    localparam int DEPTH = 4;
    localparam int GAP   = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        ir;
    logic [15:0] code_data;
    logic        code_repeat;
    logic        code_valid;
    logic        code_ready;
    logic        err;
    logic        overflow;

    always #5 clk = ~clk;

    ir_nec_receiver #(
        .TICK_DIV  (TD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ir         (ir),
        .code_data  (code_data),
        .code_repeat(code_repeat),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .err        (err),
        .overflow   (overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt = 0;
    int pop_cnt = 0;

    // Model: expected queue contents {repeat, address, command}, error count, sticky overflow.
    logic [16:0] exp_q[$];
    int          exp_err = 0;
    logic        exp_ovf;
    logic [15:0] m_last;
    logic        m_last_vld;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_ovf    = 1'b0;
        m_last     = '0;
        m_last_vld = 1'b0;
    endtask

    task automatic model_push(input logic [16:0] e);
        if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
        else exp_q.push_back(e);
    endtask

    task automatic model_frame(input logic [31:0] w);
        if (w[7:0] != ~w[15:8]) begin
            exp_err++;
        end else begin
            m_last     = {w[31:24], w[15:8]};
            m_last_vld = 1'b1;
            model_push({1'b0, w[31:24], w[15:8]});
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
        return {a, 8'h00, c, ~c};
    endfunction

    // Compare process: every popped head must match the model's oldest entry; an empty queue shows zeros.
    always @(negedge clk) begin
        if (!rst) begin
            if (code_valid && code_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) check("pop_model_empty", 32'(exp_q.size()), 32'd1);
                else check("pop_head", 32'({code_repeat, code_data}), 32'(exp_q.pop_front()));
            end
            if (!code_valid) check("empty_head", 32'({code_repeat, code_data}), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (!rst && err) err_cnt++;
    end

    task automatic hold(input logic lvl, input int ticks);
        ir = lvl;
        repeat (ticks * TD) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b1, 16);
            hold(1'b0, w[31 - i] ? 48 : 16);
        end
    endtask

    task automatic send_data_frame(input logic [31:0] w);
        @(negedge clk);
        hold(1'b1, 257);
        hold(1'b0, 128);
        send_bits(w, 32);
        hold(1'b1, 16);
        ir = 1'b0;
        model_frame(w);
    endtask

    task automatic send_repeat();
        @(negedge clk);
        hold(1'b1, 257);
        hold(1'b0, 64);
        hold(1'b1, 16);
        ir = 1'b0;
`ifdef IR_NEC_REPEAT_EN
        if (m_last_vld) model_push({1'b1, m_last});
`endif
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 code_ready = v;
    endtask

    task automatic drain();
        int k;
        set_ready(1'b1);
        k = 0;
        while (code_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain_done", 32'(code_valid), 32'd0);
        check("drain_model_empty", 32'(exp_q.size()), 32'd0);
        set_ready(1'b0);
    endtask

    task automatic checkpoint(input string tag);
        check({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        check({tag, "_valid"}, 32'(code_valid), 32'(exp_q.size() != 0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] ovf_words [5];
    int          p0;
    int          e0;

    initial begin
        ovf_words = '{mk(8'h01, 8'h10), mk(8'h02, 8'h21), mk(8'h80, 8'h42),
                      mk(8'h03, 8'h84), mk(8'h04, 8'h08)};
        rst        = 1'b1;
        ir         = 1'b0;
        code_ready = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        check("rst_valid", 32'(code_valid), 32'd0);
        check("rst_data", 32'(code_data), 32'd0);
        check("rst_repeat", 32'(code_repeat), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        hold(1'b0, 20);

        // Reference frame and push latency.
        send_data_frame(32'h00FF629D);
        repeat (2) @(negedge clk);
        check("t1_valid_early", 32'(code_valid), 32'd0);
        @(negedge clk);
        check("t1_valid_rise", 32'(code_valid), 32'd1);
        check("t1_data", 32'(code_data), 32'h0062);
        check("t1_repeat", 32'(code_repeat), 32'd0);
        hold(1'b0, GAP);
        checkpoint("t1");
        check("t1_no_err", 32'(err_cnt), 32'd0);
        drain();

        // Inverted-command mismatch.
        send_data_frame(32'h0000629C);
        hold(1'b0, GAP);
        checkpoint("t2");
        check("t2_err_pulses", 32'(err_cnt), 32'd1);
        check("t2_valid", 32'(code_valid), 32'd0);

        // Five frames into a four-deep queue.
        for (int i = 0; i < 5; i++) begin
            send_data_frame(ovf_words[i]);
            hold(1'b0, GAP);
            if (i == 3) check("t3_no_ovf_at_4", 32'(overflow), 32'd0);
        end
        check("t3_ovf", 32'(overflow), 32'd1);
        check("t3_head", 32'(code_data), 32'h0110);
        checkpoint("t3");
        p0 = pop_cnt;
        drain();
        check("t3_pops", 32'(pop_cnt - p0), 32'd4);
        check("t3_ovf_sticky", 32'(overflow), 32'd1);

        // Data frame followed by a repeat code.
        send_data_frame(mk(8'h00, 8'hE2));
        hold(1'b0, GAP);
        send_repeat();
        hold(1'b0, GAP);
        checkpoint("t4");
        check("t4_head", 32'(code_data), 32'h00E2);
        check("t4_head_rep", 32'(code_repeat), 32'd0);
        set_ready(1'b1);
        set_ready(1'b0);
        @(negedge clk);
`ifdef IR_NEC_REPEAT_EN
        check("t4_rep_data", 32'(code_data), 32'h00E2);
        check("t4_rep_flag", 32'(code_repeat), 32'd1);
`else
        check("t4_rep_dropped", 32'(code_valid), 32'd0);
`endif
        drain();

        // Reset in the middle of the data bits.
        @(negedge clk);
        hold(1'b1, 257);
        hold(1'b0, 128);
        send_bits(mk(8'h12, 8'h34), 10);
        e0  = err_cnt;
        rst = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        hold(1'b0, GAP);
        check("t5_no_err", 32'(err_cnt - e0), 32'd0);
        check("t5_ovf_cleared", 32'(overflow), 32'd0);
        check("t5_valid", 32'(code_valid), 32'd0);

        // Short leader mark, then a valid frame consumed on the fly.
        @(negedge clk);
        hold(1'b1, 200);
        ir = 1'b0;
        exp_err++;
        hold(1'b0, GAP);
        checkpoint("t6");
        set_ready(1'b1);
        p0 = pop_cnt;
        send_data_frame(mk(8'hA5, 8'h3C));
        hold(1'b0, GAP);
        check("t6_pop", 32'(pop_cnt - p0), 32'd1);
        checkpoint("t6b");
        set_ready(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
